// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants for the execute-stage issue front end.
// Holds the datapath/register-file default sizes and the ALU opcode map
// that the issue stage forwards verbatim to the ALU.
package alu_issue_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_NREGS  = 16;
    localparam int ALU_IMM_W  = 16;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_RSUB = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_SAR  = 4'd8;
    localparam logic [3:0] ALU_NOT  = 4'd9;
    localparam logic [3:0] ALU_MOV  = 4'd10;
    localparam logic [3:0] ALU_ORHI = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_LE   = 4'd13;
    localparam logic [3:0] ALU_EQ   = 4'd14;
    localparam logic [3:0] ALU_ONE  = 4'd15;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction-in, ALU and retire-out signal bundle of the
// issue stage. The slave modport is the issue stage's view; the master
// modport is the view of whoever feeds instructions, models the ALU and
// consumes retired results.
interface alu_issue_if
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int IMM_W  = ALU_IMM_W
);
    localparam int RW = $clog2(NREGS);

    // instruction input handshake
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [RW-1:0]     in_rd;
    logic [RW-1:0]     in_ra;
    logic [RW-1:0]     in_rb;
    logic              in_use_imm;
    logic [IMM_W-1:0]  in_imm;

    // ALU connection
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;

    // retire output handshake
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_rd;
    logic [DATA_W-1:0] out_res;

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
        input  alu_res, out_ready,
        output in_ready, alu_op, alu_a, alu_b,
        output out_valid, out_rd, out_res
    );

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
        output alu_res, out_ready,
        input  in_ready, alu_op, alu_a, alu_b,
        input  out_valid, out_rd, out_res
    );

endinterface

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 2-read / 1-write register file for the issue stage.
// Reads are combinational; the write lands on the clock edge. Register 0
// is never written and always reads as zero. All entries reset to zero.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     i_ra,
    input  logic [RW-1:0]     i_rb,
    output logic [DATA_W-1:0] o_rda,
    output logic [DATA_W-1:0] o_rdb,
    input  logic              i_we,
    input  logic [RW-1:0]     i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Register storage: clear everything on reset, write-port updates otherwise (r0 ignored)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we && (i_wa != {RW{1'b0}})) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read ports: r0 is hardwired to zero regardless of storage contents
    always_comb begin
        o_rda = {DATA_W{1'b0}};
        o_rdb = {DATA_W{1'b0}};
        if (i_ra != {RW{1'b0}}) begin
            o_rda = r_mem[i_ra];
        end else begin
            o_rda = {DATA_W{1'b0}};
        end
        if (i_rb != {RW{1'b0}}) begin
            o_rdb = r_mem[i_rb];
        end else begin
            o_rdb = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-stage front end that feeds an external combinational ALU.
// Two pipeline stages: X holds the operands driven to the ALU, W holds the
// captured result presented on the retire port. The result is written back
// to the register file on the same edge it moves from X into W, so W never
// needs a bypass path.
//
// Build option ALU_ISSUE_FORWARD_EN: when defined, an instruction whose
// source matches the producer in X takes the live ALU result directly and
// issues without a bubble (provided X is advancing). When undefined, such an
// instruction waits for the producer to leave X and reads the register file.
// Retired results are identical either way; only issue timing changes.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int NREGS  = ALU_NREGS,
    parameter int IMM_W  = ALU_IMM_W
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);

    localparam int RW = $clog2(NREGS);

    // X stage
    logic              r_x_valid;
    logic [3:0]        r_x_op;
    logic [RW-1:0]     r_x_rd;
    logic [DATA_W-1:0] r_x_a;
    logic [DATA_W-1:0] r_x_b;

    // W stage
    logic              r_w_valid;
    logic [RW-1:0]     r_w_rd;
    logic [DATA_W-1:0] r_w_res;

    // control
    logic              w_w_adv;
    logic              w_x_adv;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_hazard;
    logic              w_stall;
    logic              w_in_ready;
    logic              w_accept;

    // operand path
    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;

    assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, bus.in_imm};

    alu_issue_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RW     (RW)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ra   (bus.in_ra),
        .i_rb   (bus.in_rb),
        .o_rda  (w_rf_a),
        .o_rdb  (w_rf_b),
        .i_we   (w_x_adv),
        .i_wa   (r_x_rd),
        .i_wd   (bus.alu_res)
    );

    // Pipeline advance, read-after-write hazard detection and issue handshake
    always_comb begin
        w_w_adv    = 1'b0;
        w_x_adv    = 1'b0;
        w_haz_a    = 1'b0;
        w_haz_b    = 1'b0;
        w_hazard   = 1'b0;
        w_stall    = 1'b0;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;

        w_w_adv = !r_w_valid || bus.out_ready;
        w_x_adv = r_x_valid && w_w_adv;

        // a producer targeting r0 never creates a dependency: r0 reads as zero
        if (r_x_valid && (r_x_rd != {RW{1'b0}})) begin
            w_haz_a = (bus.in_ra == r_x_rd);
            w_haz_b = !bus.in_use_imm && (bus.in_rb == r_x_rd);
        end else begin
            w_haz_a = 1'b0;
            w_haz_b = 1'b0;
        end
        w_hazard = w_haz_a || w_haz_b;

`ifdef ALU_ISSUE_FORWARD_EN
        w_stall = w_hazard && !w_x_adv;
`else
        w_stall = w_hazard;
`endif

        w_in_ready = (!r_x_valid || w_x_adv) && !w_stall;
        w_accept   = bus.in_valid && w_in_ready;
    end

    // Operand selection: register file, zero-extended immediate, or live ALU result
    always_comb begin
        w_opa = w_rf_a;
        w_opb = w_rf_b;
`ifdef ALU_ISSUE_FORWARD_EN
        if (w_haz_a) begin
            w_opa = bus.alu_res;
        end else begin
            w_opa = w_rf_a;
        end
        if (bus.in_use_imm) begin
            w_opb = w_imm_ext;
        end else if (w_haz_b) begin
            w_opb = bus.alu_res;
        end else begin
            w_opb = w_rf_b;
        end
`else
        if (bus.in_use_imm) begin
            w_opb = w_imm_ext;
        end else begin
            w_opb = w_rf_b;
        end
`endif
    end

    // X stage: capture op/destination/operands on accept, empty when the occupant moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_valid <= 1'b0;
            r_x_op    <= 4'd0;
            r_x_rd    <= {RW{1'b0}};
            r_x_a     <= {DATA_W{1'b0}};
            r_x_b     <= {DATA_W{1'b0}};
        end else if (w_accept) begin
            r_x_valid <= 1'b1;
            r_x_op    <= bus.in_op;
            r_x_rd    <= bus.in_rd;
            r_x_a     <= w_opa;
            r_x_b     <= w_opb;
        end else if (w_x_adv) begin
            r_x_valid <= 1'b0;
        end
    end

    // W stage: capture the ALU result when X advances, empty once retired with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_valid <= 1'b0;
            r_w_rd    <= {RW{1'b0}};
            r_w_res   <= {DATA_W{1'b0}};
        end else if (w_x_adv) begin
            r_w_valid <= 1'b1;
            r_w_rd    <= r_x_rd;
            r_w_res   <= bus.alu_res;
        end else if (w_w_adv) begin
            r_w_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.alu_op    = r_x_op;
    assign bus.alu_a     = r_x_a;
    assign bus.alu_b     = r_x_b;
    assign bus.out_valid = r_w_valid;
    assign bus.out_rd    = r_w_rd;
    assign bus.out_res   = r_w_res;

endmodule
